// File: rtl/sram_like_arbiter_if.sv
// sram_like_arbiter_if: one sram-like request/response port.
// A master drives req and the request fields and receives addr_ok/data_ok/rdata.
// A slave is the reverse.
interface sram_like_arbiter_if #(
    parameter int AW = 32
);
    logic          req;
    logic          wr;
    logic [1:0]    size;
    logic [3:0]    wstrb;
    logic [AW-1:0] addr;
    logic [AW-1:0] wdata;
    logic          addr_ok;
    logic          data_ok;
    logic [AW-1:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: 2:1 merge of the inst (m0) and data (m1) sram-like ports onto
// one shared slave port. The grant is held from request until addr_ok. An in-order
// ID FIFO records the owner of each accepted request and routes every slave
// data_ok/rdata back to that owner.
// Build option ARB_ROUND_ROBIN_EN: alternate grants when both masters request.
// Without it, the data port (m1) always has priority.
module sram_like_arbiter #(
    parameter int unsigned DEPTH = 4,
    parameter int          AW    = 32
) (
    input  logic                clk,
    input  logic                resetn,
    sram_like_arbiter_if.slave  m0,
    sram_like_arbiter_if.slave  m1,
    sram_like_arbiter_if.master s,
    output logic                err_unexp
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] LOCK = 1'b1;

    logic [0:0]    state;
    logic          lock_id;
    logic          err_q;
    logic          fifo_id [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   cnt;

    logic full;
    logic empty;
    logic pick;
    logic gnt;
    logic gnt_req;
    logic s_req_c;
    logic push;
    logic pop;
    logic head;

    assign full  = (cnt == FULL_CNT);
    assign empty = (cnt == '0);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_gnt;
    assign pick = (m0.req && m1.req) ? ~last_gnt : m1.req;
`else
    assign pick = m1.req;
`endif

    // Grant selection and the gated slave request. Reset forces the request low
    // so that every output stays 0 while resetn is asserted.
    always_comb begin
        gnt     = (state == LOCK) ? lock_id : pick;
        gnt_req = gnt ? m1.req : m0.req;
        s_req_c = 1'b0;
        if (state == LOCK) begin
            s_req_c = resetn & ~full & gnt_req;
        end else begin
            s_req_c = resetn & ~full & (m0.req | m1.req);
        end
    end

    assign push = s_req_c & s.addr_ok;
    assign pop  = s.data_ok & ~empty;
    assign head = fifo_id[rd_ptr];

    assign s.req   = s_req_c;
    assign s.wr    = s_req_c & (gnt ? m1.wr : m0.wr);
    assign s.size  = s_req_c ? (gnt ? m1.size  : m0.size)  : '0;
    assign s.wstrb = s_req_c ? (gnt ? m1.wstrb : m0.wstrb) : '0;
    assign s.addr  = s_req_c ? (gnt ? m1.addr  : m0.addr)  : '0;
    assign s.wdata = s_req_c ? (gnt ? m1.wdata : m0.wdata) : '0;

    assign m0.addr_ok = push & ~gnt;
    assign m1.addr_ok = push & gnt;
    assign m0.data_ok = pop & ~head;
    assign m1.data_ok = pop & head;
    assign m0.rdata   = (pop & ~head) ? s.rdata : '0;
    assign m1.rdata   = (pop & head)  ? s.rdata : '0;

    assign err_unexp = err_q;

    // Grant-hold FSM: a stalled request locks the grant until it is accepted or withdrawn.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            lock_id <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_req_c && !s.addr_ok) begin
                        state   <= LOCK;
                        lock_id <= gnt;
                    end
                end
                LOCK: begin
                    if (push || !gnt_req) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // In-order requester-ID FIFO; pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_id[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                fifo_id[wr_ptr] <= gnt;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Sticky flag for a slave response that arrives with no transaction outstanding.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_q <= 1'b0;
        end else if (s.data_ok && empty) begin
            err_q <= 1'b1;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Remember the most recently accepted requester for alternation.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_gnt <= 1'b0;
        end else if (push) begin
            last_gnt <= gnt;
        end
    end
`endif
endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter: directed scenarios plus a randomized run checked against
// a queue-based reference model of the arbiter.
module tb_sram_like_arbiter;
    localparam int unsigned DEPTH = 4;
    localparam int          AW    = 32;

    logic clk = 1'b0;
    logic resetn;
    logic err_unexp;

    always #5 clk = ~clk;

    sram_like_arbiter_if #(.AW(AW)) m0_if ();
    sram_like_arbiter_if #(.AW(AW)) m1_if ();
    sram_like_arbiter_if #(.AW(AW)) s_if ();

    sram_like_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .m0        (m0_if),
        .m1        (m1_if),
        .s         (s_if),
        .err_unexp (err_unexp)
    );

    int vectors     = 0;
    int miscompares = 0;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int id, input bit req, input logic [31:0] addr);
        if (id == 0) begin
            m0_if.req = req; m0_if.wr = addr[0]; m0_if.size = addr[2:1];
            m0_if.wstrb = addr[7:4]; m0_if.addr = addr; m0_if.wdata = ~addr;
        end else begin
            m1_if.req = req; m1_if.wr = addr[0]; m1_if.size = addr[2:1];
            m1_if.wstrb = addr[7:4]; m1_if.addr = addr; m1_if.wdata = ~addr;
        end
    endtask

    task automatic set_s(input bit addr_ok, input bit data_ok, input logic [31:0] rdata);
        s_if.addr_ok = addr_ok;
        s_if.data_ok = data_ok;
        s_if.rdata   = rdata;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        set_m(0, 1'b0, 32'h0);
        set_m(1, 1'b0, 32'h0);
        set_s(1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // Reset while locked with three outstanding transactions.
    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(); set_m(0, 1'b1, 32'h100 + i); set_s(1'b1, 1'b0, 32'h0);
        end
        cyc(); set_m(0, 1'b1, 32'h200); set_s(1'b0, 1'b0, 32'h0);
        cyc(); set_m(1, 1'b1, 32'h300); #2;
        vectors++;
        if (s_if.addr !== 32'h200) begin
            miscompares++; $display("FAIL reset_pre_lock_addr: got %h want %h", s_if.addr, 32'h200);
        end
        s_if.addr_ok = 1'b1;
        resetn = 1'b0;
        #1;
        vectors++;
        if (s_if.req !== 1'b0) begin
            miscompares++; $display("FAIL reset_s_req: got %b want 0", s_if.req);
        end
        vectors++;
        if ({m0_if.addr_ok, m1_if.addr_ok, s_if.addr} !== 34'h0) begin
            miscompares++; $display("FAIL reset_outputs: got %h want 0", {m0_if.addr_ok, m1_if.addr_ok, s_if.addr});
        end
        vectors++;
        if (err_unexp !== 1'b0) begin
            miscompares++; $display("FAIL reset_err: got %b want 0", err_unexp);
        end
        set_m(0, 1'b0, 32'h0); set_m(1, 1'b0, 32'h0); set_s(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        cyc(); set_m(1, 1'b1, 32'h400); #2;
        vectors++;
        if ({s_if.req, s_if.addr} !== {1'b1, 32'h400}) begin
            miscompares++; $display("FAIL reset_idle_after: got %h want %h", {s_if.req, s_if.addr}, {1'b1, 32'h400});
        end
        cyc(); set_m(1, 1'b0, 32'h0); set_s(1'b0, 1'b1, 32'h77); #2;
        vectors++;
        if ({m0_if.data_ok, m1_if.data_ok} !== 2'b00) begin
            miscompares++; $display("FAIL reset_fifo_empty: got %b want 00", {m0_if.data_ok, m1_if.data_ok});
        end
        cyc(); set_s(1'b0, 1'b0, 32'h0); #2;
        vectors++;
        if (err_unexp !== 1'b1) begin
            miscompares++; $display("FAIL reset_cnt_zero_err: got %b want 1", err_unexp);
        end
    endtask

    // Both masters requesting with an accepting slave.
    task automatic test_priority();
        bit exp_g;
        do_reset();
        cyc(); set_m(0, 1'b1, 32'hA0); set_m(1, 1'b1, 32'hA1); set_s(1'b1, 1'b0, 32'h0); #2;
        vectors++;
        if ({m0_if.addr_ok, m1_if.addr_ok, s_if.addr} !== {2'b01, 32'hA1}) begin
            miscompares++; $display("FAIL prio_first: got %h want %h", {m0_if.addr_ok, m1_if.addr_ok, s_if.addr}, {2'b01, 32'hA1});
        end
        exp_g = RR ? 1'b0 : 1'b1;
        cyc(); set_m(1, 1'b1, 32'hA2); #2;
        vectors++;
        if ({m0_if.addr_ok, m1_if.addr_ok} !== {~exp_g, exp_g}) begin
            miscompares++; $display("FAIL prio_second: got %b want %b", {m0_if.addr_ok, m1_if.addr_ok}, {~exp_g, exp_g});
        end
        cyc(); set_m(1, 1'b0, 32'h0); #2;
        vectors++;
        if ({m0_if.addr_ok, m1_if.addr_ok, s_if.addr} !== {2'b10, 32'hA0}) begin
            miscompares++; $display("FAIL prio_m0_next: got %h want %h", {m0_if.addr_ok, m1_if.addr_ok, s_if.addr}, {2'b10, 32'hA0});
        end
        cyc(); set_m(0, 1'b0, 32'h0); set_s(1'b0, 1'b0, 32'h0);
    endtask

    // Grant held on m0 through a three-cycle stall while m1 also requests.
    task automatic test_hold();
        do_reset();
        cyc(); set_m(0, 1'b1, 32'hB0); set_s(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                cyc(); set_m(1, 1'b1, 32'hB1);
            end
            #2;
            vectors++;
            if ({s_if.req, s_if.addr, m1_if.addr_ok, m0_if.addr_ok} !== {1'b1, 32'hB0, 2'b00}) begin
                miscompares++; $display("FAIL hold_stall_%0d: got %h want %h", i, {s_if.req, s_if.addr, m1_if.addr_ok, m0_if.addr_ok}, {1'b1, 32'hB0, 2'b00});
            end
        end
        cyc(); set_s(1'b1, 1'b0, 32'h0); #2;
        vectors++;
        if ({m0_if.addr_ok, m1_if.addr_ok} !== 2'b10) begin
            miscompares++; $display("FAIL hold_accept_m0: got %b want 10", {m0_if.addr_ok, m1_if.addr_ok});
        end
        cyc(); set_m(0, 1'b0, 32'h0); #2;
        vectors++;
        if ({m0_if.addr_ok, m1_if.addr_ok, s_if.addr} !== {2'b01, 32'hB1}) begin
            miscompares++; $display("FAIL hold_then_m1: got %h want %h", {m0_if.addr_ok, m1_if.addr_ok, s_if.addr}, {2'b01, 32'hB1});
        end
        cyc(); set_m(1, 1'b0, 32'h0); set_s(1'b0, 1'b0, 32'h0);
    endtask

    // Fill to DEPTH, confirm the block, then drain in order.
    task automatic test_fill_drain();
        int order [4] = '{0, 1, 1, 0};
        logic [31:0] rd [5] = '{32'hA, 32'hB, 32'hC, 32'hD, 32'hE};
        int who [5] = '{0, 1, 1, 0, 0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(); set_m(order[i], 1'b1, 32'hC0 + i); set_m(1 - order[i], 1'b0, 32'h0); set_s(1'b1, 1'b0, 32'h0); #2;
            vectors++;
            if ((order[i] == 0 ? m0_if.addr_ok : m1_if.addr_ok) !== 1'b1) begin
                miscompares++; $display("FAIL fill_accept_%0d: got 0 want 1", i);
            end
        end
        cyc(); set_m(1, 1'b0, 32'h0); set_m(0, 1'b1, 32'hCF); #2;
        vectors++;
        if ({s_if.req, m0_if.addr_ok} !== 2'b00) begin
            miscompares++; $display("FAIL full_blocks: got %b want 00", {s_if.req, m0_if.addr_ok});
        end
        for (int i = 0; i < 5; i++) begin
            cyc();
            set_s(i == 1, 1'b1, rd[i]);
            if (i == 2) set_m(0, 1'b0, 32'h0);
            #2;
            if (i < 2) begin
                vectors++;
                if ({s_if.req, m0_if.addr_ok} !== {i == 1, i == 1}) begin
                    miscompares++; $display("FAIL drain_reopen_%0d: got %b want %b", i, {s_if.req, m0_if.addr_ok}, {i == 1, i == 1});
                end
            end
            vectors++;
            if (who[i] == 0) begin
                if ({m0_if.data_ok, m0_if.rdata, m1_if.data_ok, m1_if.rdata} !== {1'b1, rd[i], 1'b0, 32'h0}) begin
                    miscompares++; $display("FAIL drain_%0d_m0: got %b/%h %b/%h want m0 %h", i, m0_if.data_ok, m0_if.rdata, m1_if.data_ok, m1_if.rdata, rd[i]);
                end
            end else begin
                if ({m0_if.data_ok, m0_if.rdata, m1_if.data_ok, m1_if.rdata} !== {1'b0, 32'h0, 1'b1, rd[i]}) begin
                    miscompares++; $display("FAIL drain_%0d_m1: got %b/%h %b/%h want m1 %h", i, m0_if.data_ok, m0_if.rdata, m1_if.data_ok, m1_if.rdata, rd[i]);
                end
            end
        end
        cyc(); set_s(1'b0, 1'b0, 32'h0); #2;
        vectors++;
        if (err_unexp !== 1'b0) begin
            miscompares++; $display("FAIL drain_no_err: got %b want 0", err_unexp);
        end
    endtask

    // Simultaneous push and pop at cnt=2 leaves exactly two outstanding.
    task automatic test_push_pop();
        do_reset();
        cyc(); set_m(1, 1'b1, 32'hD1); set_s(1'b1, 1'b0, 32'h0);
        cyc(); set_m(1, 1'b0, 32'h0); set_m(0, 1'b1, 32'hD0);
        cyc(); set_m(0, 1'b1, 32'hD2); set_s(1'b1, 1'b1, 32'h1); #2;
        vectors++;
        if ({m1_if.data_ok, m1_if.rdata, m0_if.data_ok, m0_if.addr_ok} !== {1'b1, 32'h1, 1'b0, 1'b1}) begin
            miscompares++; $display("FAIL pp_same_cycle: got %h want %h", {m1_if.data_ok, m1_if.rdata, m0_if.data_ok, m0_if.addr_ok}, {1'b1, 32'h1, 1'b0, 1'b1});
        end
        for (int i = 0; i < 2; i++) begin
            cyc(); set_m(0, 1'b0, 32'h0); set_s(1'b0, 1'b1, 32'h2 + i); #2;
            vectors++;
            if ({m0_if.data_ok, m0_if.rdata, m1_if.data_ok} !== {1'b1, 32'h2 + i, 1'b0}) begin
                miscompares++; $display("FAIL pp_pop_%0d: got %b/%h want 1/%h", i, m0_if.data_ok, m0_if.rdata, 32'h2 + i);
            end
        end
        vectors++;
        if (err_unexp !== 1'b0) begin
            miscompares++; $display("FAIL pp_err_early: got %b want 0", err_unexp);
        end
        cyc(); set_s(1'b0, 1'b1, 32'h4); #2;
        vectors++;
        if ({m0_if.data_ok, m1_if.data_ok} !== 2'b00) begin
            miscompares++; $display("FAIL pp_empty: got %b want 00", {m0_if.data_ok, m1_if.data_ok});
        end
        cyc(); set_s(1'b0, 1'b0, 32'h0);
    endtask

    // Response with nothing outstanding sets a sticky error.
    task automatic test_unexpected();
        do_reset();
        cyc(); set_s(1'b0, 1'b1, 32'h55); #2;
        vectors++;
        if ({m0_if.data_ok, m1_if.data_ok, m0_if.rdata, m1_if.rdata, err_unexp} !== 67'h0) begin
            miscompares++; $display("FAIL unexp_no_route: got %h want 0", {m0_if.data_ok, m1_if.data_ok, m0_if.rdata, m1_if.rdata, err_unexp});
        end
        cyc(); set_s(1'b0, 1'b0, 32'h0); #2;
        vectors++;
        if (err_unexp !== 1'b1) begin
            miscompares++; $display("FAIL unexp_set: got %b want 1", err_unexp);
        end
        cyc(); set_m(0, 1'b1, 32'hE0); set_s(1'b1, 1'b0, 32'h0);
        cyc(); set_m(0, 1'b0, 32'h0); set_s(1'b0, 1'b1, 32'h66); #2;
        vectors++;
        if ({m0_if.data_ok, m0_if.rdata} !== {1'b1, 32'h66}) begin
            miscompares++; $display("FAIL unexp_normal_pop: got %b/%h want 1/66", m0_if.data_ok, m0_if.rdata);
        end
        repeat (4) cyc();
        set_s(1'b0, 1'b0, 32'h0); #2;
        vectors++;
        if (err_unexp !== 1'b1) begin
            miscompares++; $display("FAIL unexp_sticky: got %b want 1", err_unexp);
        end
    endtask

    // Randomized traffic against a queue model of outstanding requesters.
    task automatic test_random();
        int q[$];
        int held = -1;
        int g;
        bit last = 1'b0;
        bit err_m = 1'b0;
        bit mreq [2] = '{1'b0, 1'b0};
        logic [70:0] mfld [2];
        bit exp_req, popped, full_m;
        bit aok, dok;
        logic [31:0] rdat;
        logic [70:0] exp_f;
        logic [32:0] exp_r0, exp_r1;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            cyc();
            for (int m = 0; m < 2; m++) begin
                if (!mreq[m] && $urandom_range(0, 99) < 50) begin
                    mreq[m] = 1'b1;
                    mfld[m] = {$urandom_range(0, 1) == 1, 2'($urandom), 4'($urandom), 32'($urandom), 32'($urandom)};
                end
            end
            aok  = $urandom_range(0, 99) < 60;
            dok  = (q.size() > 0) ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 3);
            rdat = $urandom;
            {m0_if.wr, m0_if.size, m0_if.wstrb, m0_if.addr, m0_if.wdata} = mfld[0];
            {m1_if.wr, m1_if.size, m1_if.wstrb, m1_if.addr, m1_if.wdata} = mfld[1];
            m0_if.req = mreq[0];
            m1_if.req = mreq[1];
            set_s(aok, dok, rdat);
            #2;
            full_m = (q.size() == DEPTH);
            if (held >= 0) begin
                g = held;
            end else if (mreq[0] && mreq[1]) begin
                g = RR ? int'(!last) : 1;
            end else begin
                g = mreq[1] ? 1 : 0;
            end
            exp_req = mreq[g] && !full_m;
            exp_f   = exp_req ? mfld[g] : '0;
            popped  = dok && q.size() > 0;
            exp_r0  = (popped && q[0] == 0) ? {1'b1, rdat} : '0;
            exp_r1  = (popped && q[0] == 1) ? {1'b1, rdat} : '0;
            vectors++;
            if (s_if.req !== exp_req) begin
                miscompares++; $display("FAIL rnd_s_req@%0d: got %b want %b", n, s_if.req, exp_req);
            end
            vectors++;
            if ({s_if.wr, s_if.size, s_if.wstrb, s_if.addr, s_if.wdata} !== exp_f) begin
                miscompares++; $display("FAIL rnd_fields@%0d: got %h want %h", n, {s_if.wr, s_if.size, s_if.wstrb, s_if.addr, s_if.wdata}, exp_f);
            end
            vectors++;
            if ({m0_if.addr_ok, m1_if.addr_ok} !== {exp_req && aok && g == 0, exp_req && aok && g == 1}) begin
                miscompares++; $display("FAIL rnd_addr_ok@%0d: got %b want %b", n, {m0_if.addr_ok, m1_if.addr_ok}, {exp_req && aok && g == 0, exp_req && aok && g == 1});
            end
            vectors++;
            if ({m0_if.data_ok, m0_if.rdata} !== exp_r0) begin
                miscompares++; $display("FAIL rnd_m0_resp@%0d: got %h want %h", n, {m0_if.data_ok, m0_if.rdata}, exp_r0);
            end
            vectors++;
            if ({m1_if.data_ok, m1_if.rdata} !== exp_r1) begin
                miscompares++; $display("FAIL rnd_m1_resp@%0d: got %h want %h", n, {m1_if.data_ok, m1_if.rdata}, exp_r1);
            end
            vectors++;
            if (err_unexp !== err_m) begin
                miscompares++; $display("FAIL rnd_err@%0d: got %b want %b", n, err_unexp, err_m);
            end
            if (dok && q.size() == 0) err_m = 1'b1;
            if (popped) void'(q.pop_front());
            if (exp_req && aok) begin
                q.push_back(g);
                last    = (g == 1);
                held    = -1;
                mreq[g] = 1'b0;
            end else if (held < 0 && exp_req) begin
                held = g;
            end
        end
        cyc();
        set_m(0, 1'b0, 32'h0); set_m(1, 1'b0, 32'h0); set_s(1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        test_reset();
        test_priority();
        test_hold();
        test_fill_drain();
        test_push_pop();
        test_unexpected();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
